debugport_ctrl: RTL and testbench

- Memory-mapped debug output peripheral; sits between processor_block's data bus and the top-level debugport/debugport_en pins.
- Processor writes bytes into an internal FIFO.
- An output FSM drains the FIFO onto debugport, one byte per single-cycle debugport_en strobe, with programmable inter-byte gap.
- Provides status readback so firmware can poll for space.

---
 rtl/debugport_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_debugport_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debugport_ctrl.sv
// debugport_ctrl: memory-mapped byte FIFO drained onto a strobed debug port.
// Registers: 0x0 DATA, 0x4 CTRL, 0x8 STATUS, 0xC OVFCNT (optional).
// Optional feature macro: DEBUGPORT_OVF_COUNT_EN enables the 16-bit saturating
// dropped-push counter at 0xC; without it 0xC reads 0 and writes are ignored.
module debugport_ctrl #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  GAP_RESET  = 8'd0,
  parameter logic        EN_RESET   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        debugport_en,
  output logic [7:0]  debugport
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = AW + 1;

  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegCtrl   = 2'd1;
  localparam logic [1:0] RegStatus = 2'd2;
  localparam logic [1:0] RegOvfCnt = 2'd3;

  typedef enum logic [1:0] {StIdle, StEmit, StGap} state_e;

  // Bus decode
  logic [1:0]  w_sel;
  logic        w_wr;
  logic        w_push_req;
  logic        w_ctrl_wr;
  logic        w_status_wr;
  logic        w_flush;

  // FIFO
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic [7:0]    w_level8;

  // Control / status
  logic        r_enable;
  logic [7:0]  r_gap;
  logic        r_ovf;
  logic [31:0] w_ovfcnt_rd;
  logic [31:0] w_rdata;

  // Response
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;

  // Output FSM
  state_e      r_state;
  state_e      w_state_next;
  logic [7:0]  r_cnt;
  logic        w_cnt_load;
  logic        w_cnt_dec;
  logic        r_dp_en;
  logic [7:0]  r_dp;

  logic        w_unused;

  assign w_sel       = req_addr[3:2];
  assign w_wr        = req_valid && req_write;
  assign w_push_req  = w_wr && (w_sel == RegData);
  assign w_ctrl_wr   = w_wr && (w_sel == RegCtrl);
  assign w_status_wr = w_wr && (w_sel == RegStatus);
  assign w_flush     = w_ctrl_wr && req_wdata[1];

  // Full/empty reflect the level at the start of the cycle; a push to a full
  // FIFO is dropped even if the FSM pops in the same cycle.
  assign w_full   = (r_level == LW'(FIFO_DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_push   = w_push_req && !w_full;
  assign w_drop   = w_push_req && w_full;
  assign w_level8 = 8'(r_level);

  // Only the low address bits and upper write-data half carry no meaning
  assign w_unused = ^{req_addr[1:0], req_wdata[31:16]};

  // FIFO storage; contents need no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= req_wdata[7:0];
    end
  end

  // FIFO pointers and level; flush wins over a same-cycle pop
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // CTRL fields and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_enable <= EN_RESET;
      r_gap    <= GAP_RESET;
      r_ovf    <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_enable <= req_wdata[0];
        r_gap    <= req_wdata[15:8];
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_status_wr && req_wdata[2]) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef DEBUGPORT_OVF_COUNT_EN
  logic        w_ovfcnt_wr;
  logic [15:0] r_ovf_cnt;

  assign w_ovfcnt_wr = w_wr && (w_sel == RegOvfCnt);
  assign w_ovfcnt_rd = {16'h0, r_ovf_cnt};

  // Saturating count of dropped pushes; any write to OVFCNT clears it
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ovf_cnt <= 16'h0;
    end else if (w_ovfcnt_wr) begin
      r_ovf_cnt <= 16'h0;
    end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end
`else
  assign w_ovfcnt_rd = 32'h0;
`endif

  // Read data mux from current register state
  always_comb begin
    w_rdata = 32'h0;
    unique case (w_sel)
      RegData:   w_rdata = 32'h0;
      RegCtrl:   w_rdata = {16'h0, r_gap, 7'h0, r_enable};
      RegStatus: w_rdata = {16'h0, w_level8, 5'h0, r_ovf, w_empty, w_full};
      RegOvfCnt: w_rdata = w_ovfcnt_rd;
      default:   w_rdata = 32'h0;
    endcase
  end

  // Registered response one cycle after every request; writes return 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      r_rsp_valid <= req_valid;
      r_rsp_rdata <= (req_valid && !req_write) ? w_rdata : 32'h0;
    end
  end

  // Output FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Output FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (r_enable && !w_empty) begin
          w_state_next = StEmit;
        end
      end
      StEmit: begin
        w_state_next = (r_gap != 8'd0) ? StGap : StIdle;
      end
      StGap: begin
        if (r_cnt <= 8'd1) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Output FSM decoded controls; EMIT entered via a flush race pops nothing
  always_comb begin
    w_pop      = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    unique case (r_state)
      StEmit: begin
        w_pop      = !w_empty;
        w_cnt_load = 1'b1;
      end
      StGap: begin
        w_cnt_dec = (r_cnt != 8'd0);
      end
      default: begin
        w_pop = 1'b0;
      end
    endcase
  end

  // Gap counter: loaded with the gap sampled at EMIT, so later CTRL writes
  // only affect the following byte
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= 8'd0;
    end else if (w_cnt_load) begin
      r_cnt <= r_gap;
    end else if (w_cnt_dec) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  // Registered debug port; the byte holds between strobes
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dp_en <= 1'b0;
      r_dp    <= 8'h00;
    end else begin
      r_dp_en <= w_pop;
      if (w_pop) begin
        r_dp <= r_mem[r_rd_ptr];
      end
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign debugport_en = r_dp_en;
  assign debugport    = r_dp;

endmodule

// File: tb/tb_debugport_ctrl.sv
// Bench for debugport_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all continuously compared against a queue-based model.
module tb_debugport_ctrl;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [3:0]  req_addr = 4'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        debugport_en;
  logic [7:0]  debugport;

  always #5 clk = ~clk;

  debugport_ctrl #(
    .FIFO_DEPTH(DEPTH),
    .GAP_RESET (8'd0),
    .EN_RESET  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .debugport_en(debugport_en),
    .debugport   (debugport)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  logic [7:0]  mq[$];
  logic        m_enable;
  logic [7:0]  m_gap;
  logic        m_ovf;
  int          m_ovfcnt;
  logic        m_emit;      // a byte is due to leave the queue this cycle
  int          last_emit;   // cycle of the last emit slot
  int          gap_used;    // gap in force at that emit slot
  logic        m_valid = 1'b0;
  logic        m_rsp_valid;
  logic [31:0] m_rsp_rdata;
  logic        m_en;
  logic [7:0]  m_dp;

  always @(posedge clk) begin : model
    int         t;
    logic       full, empty, busy_free, nxt, push_req, flush, pop;
    logic [1:0] sel;
    logic [31:0] rd;
    t = cyc;
    if (!rst) begin
      mq.delete();
      m_enable = 1'b1;
      m_gap = 8'd0;
      m_ovf = 1'b0;
      m_ovfcnt = 0;
      m_emit = 1'b0;
      last_emit = -1000;
      gap_used = 0;
      m_rsp_valid = 1'b0;
      m_rsp_rdata = 32'h0;
      m_en = 1'b0;
      m_dp = 8'h00;
      m_valid = 1'b1;
    end else begin
      full  = (mq.size() == DEPTH);
      empty = (mq.size() == 0);
      sel   = req_addr[3:2];
      rd    = 32'h0;
      if (req_valid && !req_write) begin
        if (sel == 2'd1) rd = {16'h0, m_gap, 7'h0, m_enable};
        else if (sel == 2'd2) rd = {16'h0, 8'(mq.size()), 5'h0, m_ovf, empty, full};
`ifdef DEBUGPORT_OVF_COUNT_EN
        else if (sel == 2'd3) rd = 32'(m_ovfcnt);
`endif
      end
      m_rsp_valid = req_valid;
      m_rsp_rdata = rd;
      pop  = m_emit && !empty;
      m_en = pop;
      if (pop) m_dp = mq[0];
      // Free to start another byte once the last slot and its gap have elapsed
      busy_free = !m_emit && (t > last_emit + gap_used);
      nxt = busy_free && m_enable && !empty;
      if (m_emit) begin
        last_emit = t;
        gap_used = int'(m_gap);
      end
      push_req = req_valid && req_write && (sel == 2'd0);
      flush    = req_valid && req_write && (sel == 2'd1) && req_wdata[1];
      if (flush) mq.delete();
      else if (pop) void'(mq.pop_front());
      if (push_req) begin
        if (full) begin
          m_ovf = 1'b1;
          if (m_ovfcnt < 65535) m_ovfcnt++;
        end else begin
          mq.push_back(req_wdata[7:0]);
        end
      end
      if (req_valid && req_write && (sel == 2'd1)) begin
        m_enable = req_wdata[0];
        m_gap = req_wdata[15:8];
      end
      if (req_valid && req_write && (sel == 2'd2) && req_wdata[2]) m_ovf = 1'b0;
      if (req_valid && req_write && (sel == 2'd3)) m_ovfcnt = 0;
      m_emit = nxt;
    end
    cyc++;
  end

  // ---------------- compare process and strobe log ----------------
  int         log_cyc[$];
  logic [7:0] log_dp[$];

  always @(negedge clk) begin
    if (m_valid) begin
      check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
      if (m_rsp_valid) check("rsp_rdata", rsp_rdata, m_rsp_rdata);
      check("debugport_en", 32'(debugport_en), 32'(m_en));
      check("debugport", 32'(debugport), 32'(m_dp));
    end
    if (debugport_en) begin
      log_cyc.push_back(cyc);
      log_dp.push_back(debugport);
    end
  end

  // ---------------- bus helpers (called at negedge) ----------------
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = a;
    @(negedge clk);
    req_valid = 1'b0;
    d = rsp_rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_dp.delete();
  endtask

  task automatic wait_strobe(input string name);
    int n;
    n = 0;
    while (!debugport_en && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(debugport_en), 32'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    int w0;
    logic [1:0] sel;
    int r;

    rst = 1'b0;
    idle(3);
    rst = 1'b1;

    // Reset values
    check("reset_debugport_en", 32'(debugport_en), 32'h0);
    check("reset_debugport", 32'(debugport), 32'h0);
    bus_read(4'h4, rd);
    check("reset_ctrl", rd, 32'h0000_0001);
    bus_read(4'h8, rd);
    check("reset_status", rd, 32'h0000_0002);

    // Three bytes at gap 0: strobes at write+3, +5, +7
    clear_log();
    w0 = cyc;
    bus_write(4'h0, 32'h41);
    bus_write(4'h0, 32'h42);
    bus_write(4'h0, 32'h43);
    idle(12);
    check("t2_strobe_count", 32'(log_cyc.size()), 32'd3);
    if (log_cyc.size() >= 3) begin
      check("t2_cyc0", 32'(log_cyc[0] - w0), 32'd3);
      check("t2_cyc1", 32'(log_cyc[1] - w0), 32'd5);
      check("t2_cyc2", 32'(log_cyc[2] - w0), 32'd7);
      check("t2_byte0", 32'(log_dp[0]), 32'h41);
      check("t2_byte1", 32'(log_dp[1]), 32'h42);
      check("t2_byte2", 32'(log_dp[2]), 32'h43);
    end
    check("t2_hold", 32'(debugport), 32'h43);

    // Gap 5: strobes 7 cycles apart
    bus_write(4'h4, 32'h0000_0501);
    clear_log();
    bus_write(4'h0, 32'h10);
    bus_write(4'h0, 32'h11);
    idle(20);
    check("t3_strobe_count", 32'(log_cyc.size()), 32'd2);
    if (log_cyc.size() >= 2) check("t3_spacing", 32'(log_cyc[1] - log_cyc[0]), 32'd7);
    bus_read(4'h8, rd);
    check("t3_status", rd, 32'h0000_0002);

    // Disabled, 17 pushes: full, overflow, no strobes
    bus_write(4'h4, 32'h0);
    clear_log();
    for (int i = 0; i < 17; i++) bus_write(4'h0, 32'h80 + 32'(i));
    bus_read(4'h8, rd);
    check("t4_status_full", rd, 32'h0000_1005);
    check("t4_no_strobes", 32'(log_cyc.size()), 32'd0);
    bus_write(4'h8, 32'h4);
    bus_read(4'h8, rd);
    check("t4_status_ovf_clr", rd, 32'h0000_1001);
    bus_read(4'hC, rd);
`ifdef DEBUGPORT_OVF_COUNT_EN
    check("t4_ovfcnt", rd, 32'h1);
`else
    check("t4_reg_c", rd, 32'h0);
`endif
    bus_write(4'h4, 32'h2);
    bus_read(4'h8, rd);
    check("t4_status_flushed", rd, 32'h0000_0002);

    // Disable during GAP: exactly one strobe, then resume in order
    bus_write(4'h4, 32'h0000_0300);
    for (int i = 0; i < 4; i++) bus_write(4'h0, 32'hA0 + 32'(i));
    clear_log();
    bus_write(4'h4, 32'h0000_0301);
    wait_strobe("t5_first_strobe");
    bus_write(4'h4, 32'h0000_0300);
    idle(15);
    check("t5_one_strobe", 32'(log_cyc.size()), 32'd1);
    if (log_dp.size() >= 1) check("t5_byte0", 32'(log_dp[0]), 32'hA0);
    bus_read(4'h8, rd);
    check("t5_status_level3", rd, 32'h0000_0300);
    bus_write(4'h4, 32'h0000_0301);
    idle(30);
    check("t5_all_strobes", 32'(log_cyc.size()), 32'd4);
    if (log_dp.size() >= 4) begin
      check("t5_byte1", 32'(log_dp[1]), 32'hA1);
      check("t5_byte2", 32'(log_dp[2]), 32'hA2);
      check("t5_byte3", 32'(log_dp[3]), 32'hA3);
    end

    // Flush with 5 queued, then a single byte still flows
    bus_write(4'h4, 32'h0);
    for (int i = 0; i < 5; i++) bus_write(4'h0, 32'h60 + 32'(i));
    clear_log();
    bus_write(4'h4, 32'h3);
    bus_read(4'h8, rd);
    check("t6_status_flushed", rd, 32'h0000_0002);
    idle(10);
    check("t6_no_strobes", 32'(log_cyc.size()), 32'd0);
    bus_write(4'h0, 32'h55);
    idle(10);
    check("t6_strobe_count", 32'(log_cyc.size()), 32'd1);
    if (log_dp.size() >= 1) check("t6_byte", 32'(log_dp[0]), 32'h55);

    // Reset mid-stream
    bus_write(4'h4, 32'h0);
    for (int i = 0; i < 3; i++) bus_write(4'h0, 32'h70 + 32'(i));
    bus_write(4'h4, 32'h0000_0301);
    wait_strobe("t7_first_strobe");
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("t7_en_after_rst", 32'(debugport_en), 32'h0);
    check("t7_dp_after_rst", 32'(debugport), 32'h0);
    bus_read(4'h8, rd);
    check("t7_status", rd, 32'h0000_0002);
    bus_read(4'h4, rd);
    check("t7_ctrl", rd, 32'h0000_0001);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) != 0);
      req_valid = ($urandom_range(0, 1) == 1);
      req_write = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 9));
      if (r < 5) sel = 2'd0;
      else if (r < 7) sel = 2'd1;
      else if (r < 9) sel = 2'd2;
      else sel = 2'd3;
      req_addr = {sel, 2'($urandom_range(0, 3))};
      req_wdata = $urandom;
      if (sel == 2'd1) begin
        req_wdata[15:8] = 8'($urandom_range(0, 4));
        req_wdata[0] = ($urandom_range(0, 7) != 0);
        req_wdata[1] = ($urandom_range(0, 15) == 0);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
